// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control <-> datapath/memory bundle for the multicycle RV32I core
// master (control FSM): takes op/funct3/funct7_5/zero/mem_ready, drives selects and enables
// slave (datapath side): the reverse view
interface multicycle_control_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       illegal_instr;
    modport master (
        input  op, funct3, funct7_5, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal_instr
    );
    modport slave (
        output op, funct3, funct7_5, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal_instr
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM sequencing the shared multicycle RV32I datapath
// Ports: clk (rising edge), rst (async active-high), bus (multicycle_control_if.master):
//   instruction fields, ALU zero and memory ready in; memory request/strobe, mux selects,
//   write enables, ALU control, imm_src and the sticky illegal_instr trap flag out.
module multicycle_control #(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input logic clk,
    input logic rst,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXEC_R, EXEC_I, ALUWB, BEQ, JAL, TRAP
    } state_t;
    // aluop: 0 add, 1 sub, 2 R-type funct decode, 3 I-type funct decode
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       illegal;
    } ctl_t;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
    localparam state_t START = RESET_STATE_FETCH ? FETCH : IDLE;
    state_t     state, next;
    ctl_t       ctl, ctl_next;
    logic       done, funct_ok;
    logic [2:0] funct_alu;
    // An access completes only while a request is registered, so the first cycle after
    // reset (outputs still cleared) cannot consume a stray mem_ready.
    assign done     = ctl.mem_req && bus.mem_ready;
    assign funct_ok = bus.funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
    always_comb begin
        next = state;
        case (state)
            IDLE:     next = bus.mem_ready ? FETCH : IDLE;
            FETCH:    next = done ? DECODE : FETCH;
            DECODE:   next = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                             bus.op == OP_R   ? EXEC_R :
                             bus.op == OP_I   ? EXEC_I :
                             bus.op == OP_BEQ ? BEQ :
                             bus.op == OP_JAL ? JAL : TRAP;
            MEMADR:   next = bus.op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  next = done ? MEMWB : MEMREAD;
            MEMWRITE: next = done ? FETCH : MEMWRITE;
            MEMWB, ALUWB, BEQ: next = FETCH;
            EXEC_R, EXEC_I:    next = funct_ok ? ALUWB : TRAP;
            JAL:      next = ALUWB;
            default:  next = TRAP;
        endcase
    end
    // Moore outputs are computed for the state being entered and registered with it.
    always_comb begin
        ctl_next = '0;
        case (next)
            FETCH:    begin ctl_next.mem_req = 1'b1; ctl_next.alu_src_b = 2'd2; ctl_next.result_src = 2'd2; end
            DECODE:   begin ctl_next.alu_src_a = 2'd1; ctl_next.alu_src_b = 2'd1; end
            MEMADR:   begin ctl_next.alu_src_a = 2'd2; ctl_next.alu_src_b = 2'd1; end
            MEMREAD:  begin ctl_next.mem_req = 1'b1; ctl_next.adr_src = 1'b1; end
            MEMWB:    begin ctl_next.result_src = 2'd1; ctl_next.reg_write = 1'b1; end
            MEMWRITE: begin ctl_next.mem_req = 1'b1; ctl_next.mem_write = 1'b1; ctl_next.adr_src = 1'b1; end
            EXEC_R:   begin ctl_next.alu_src_a = 2'd2; ctl_next.aluop = 2'd2; end
            EXEC_I:   begin ctl_next.alu_src_a = 2'd2; ctl_next.alu_src_b = 2'd1; ctl_next.aluop = 2'd3; end
            ALUWB:    ctl_next.reg_write = 1'b1;
            BEQ:      begin ctl_next.alu_src_a = 2'd2; ctl_next.aluop = 2'd1; end
            JAL:      begin ctl_next.alu_src_a = 2'd1; ctl_next.alu_src_b = 2'd2; end
            TRAP:     ctl_next.illegal = 1'b1;
            default:  ctl_next = '0;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START;
            ctl   <= '0;
        end else begin
            state <= next;
            ctl   <= ctl_next;
        end
    end
    assign funct_alu = bus.funct3 == 3'b010 ? 3'b101 :
                       bus.funct3 == 3'b110 ? 3'b011 :
                       bus.funct3 == 3'b111 ? 3'b010 :
                       (ctl.aluop == 2'd2 && bus.funct7_5) ? 3'b001 : 3'b000;
    assign bus.alu_control   = ctl.aluop == 2'd0 ? 3'b000 : ctl.aluop == 2'd1 ? 3'b001 : funct_alu;
    assign bus.mem_req       = ctl.mem_req;
    assign bus.mem_write     = ctl.mem_write;
    assign bus.adr_src       = ctl.adr_src;
    assign bus.reg_write     = ctl.reg_write;
    assign bus.result_src    = ctl.result_src;
    assign bus.alu_src_a     = ctl.alu_src_a;
    assign bus.alu_src_b     = ctl.alu_src_b;
    assign bus.illegal_instr = ctl.illegal;
    assign bus.ir_write      = state == FETCH && done;
    assign bus.pc_write      = (state == FETCH && done) || (state == BEQ && bus.zero) || state == JAL;
    // imm_src follows op in every state but is forced low while reset is held.
    assign bus.imm_src       = rst ? 2'd0 : bus.op == OP_SW ? 2'd1 : bus.op == OP_BEQ ? 2'd2 :
                               bus.op == OP_JAL ? 2'd3 : 2'd0;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: self-checking bench for multicycle_control against a transaction-level model
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    multicycle_control_if bus_if();
    multicycle_control dut (.clk(clk), .rst(rst), .bus(bus_if));
    int checks = 0;
    int errors = 0;
    int rw_seen = 0;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
    // instruction kinds: 0 lw, 1 sw, 2 R-type, 3 I-type, 4 beq, 5 jal
    logic [6:0] ops [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    int base_lat [6]    = '{5, 4, 4, 4, 3, 4};
    int imm_exp [6]     = '{0, 1, 0, 0, 2, 3};
    logic [2:0] legal_f3 [4] = '{3'b000, 3'b010, 3'b110, 3'b111};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {14'd0, bus_if.mem_req, bus_if.mem_write, bus_if.adr_src, bus_if.ir_write,
                bus_if.pc_write, bus_if.reg_write, bus_if.result_src, bus_if.alu_src_a,
                bus_if.alu_src_b, bus_if.alu_control, bus_if.imm_src, bus_if.illegal_instr};
    endfunction

    function automatic logic [2:0] exp_alu(input int k, input logic [2:0] f3, input logic f7);
        if (k == 4) return 3'b001;
        if (k < 2 || k == 5) return 3'b000;
        case (f3)
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return (k == 2 && f7) ? 3'b001 : 3'b000;
        endcase
    endfunction

    // Called at the negedge after rst was raised: release it and expect FETCH one edge later.
    task automatic release_rst();
        rst = 1'b0;
        @(negedge clk);
        chk("fetch after rst", {bus_if.mem_req, bus_if.adr_src, bus_if.alu_src_a, bus_if.alu_src_b,
                                bus_if.result_src, bus_if.alu_control}, {1'b1, 1'b0, 2'd0, 2'd2, 2'd2, 3'b000});
    endtask

    task automatic step(input logic rdy);
        bus_if.mem_ready = rdy;
        #1;
        rw_seen += int'(bus_if.reg_write);
        @(negedge clk);
    endtask

    // Starts at the negedge of a FETCH cycle; memory answers sf / sm cycles late for the
    // fetch / data access. Ends at the negedge of the following FETCH.
    task automatic run_instr(input int k, input logic [2:0] f3, input logic f7, input logic z,
                             input int sf, input int sm);
        int cyc = 0, regw = 0, wb_cyc = 0, wb_rs = 0, memw = 0, pcw = 0, irw = 0;
        int immbad = 0, ill = 0, rs1_cnt = 0, wait_left = sf;
        logic [2:0] alu = 3'b000;
        bit fetched = 0, fin = 0, writes;
        writes = (k == 0 || k == 2 || k == 3 || k == 5);
        bus_if.op = ops[k]; bus_if.funct3 = f3; bus_if.funct7_5 = f7; bus_if.zero = z;
        for (int c = 0; c < 64 && !fin; c++) begin
            if (fetched && bus_if.mem_req && !bus_if.adr_src) fin = 1;
            else begin
                bus_if.mem_ready = bus_if.mem_req && wait_left == 0;
                #1;
                cyc++;
                if (bus_if.reg_write) begin regw++; wb_cyc = cyc; wb_rs = int'(bus_if.result_src); end
                memw   += int'(bus_if.mem_write);
                pcw    += int'(bus_if.pc_write);
                irw    += int'(bus_if.ir_write);
                ill    += int'(bus_if.illegal_instr);
                immbad += (int'(bus_if.imm_src) != imm_exp[k]) ? 1 : 0;
                if (bus_if.alu_src_a == 2'd2) begin rs1_cnt++; alu = bus_if.alu_control; end
                if (bus_if.ir_write) fetched = 1;
                if (bus_if.mem_req) wait_left = (wait_left == 0) ? sm : wait_left - 1;
                @(negedge clk);
            end
        end
        chk($sformatf("completed k%0d", k), 32'(fin), 1);
        chk($sformatf("cycles k%0d", k), cyc, base_lat[k] + sf + ((k < 2) ? sm : 0));
        chk($sformatf("reg_write pulses k%0d", k), regw, 32'(writes));
        if (writes) begin
            chk($sformatf("wb cycle k%0d", k), wb_cyc, cyc);
            chk($sformatf("wb result_src k%0d", k), wb_rs, (k == 0) ? 1 : 0);
        end
        chk($sformatf("mem_write cycles k%0d", k), memw, (k == 1) ? 1 + sm : 0);
        chk($sformatf("pc_write pulses k%0d", k), pcw, 1 + ((k == 5) ? 1 : 0) + ((k == 4 && z) ? 1 : 0));
        chk($sformatf("ir_write pulses k%0d", k), irw, 1);
        chk($sformatf("imm_src wrong cycles k%0d", k), immbad, 0);
        chk($sformatf("rs1 cycles k%0d", k), rs1_cnt, (k == 5) ? 0 : 1);
        if (k != 5) chk($sformatf("alu_control k%0d f3=%0d f7=%0d", k, f3, f7), 32'(alu), 32'(exp_alu(k, f3, f7)));
        chk($sformatf("illegal k%0d", k), ill, 0);
    endtask

    task automatic trap_test(input logic [6:0] op, input logic [2:0] f3, input int exp_idx);
        int t = -1, busy = 0, held = 0;
        bus_if.op = op; bus_if.funct3 = f3; bus_if.funct7_5 = 1'b0;
        for (int c = 0; c < 12 && t < 0; c++) begin
            bus_if.mem_ready = 1'b1;
            #1;
            if (bus_if.illegal_instr) t = c;
            @(negedge clk);
        end
        chk($sformatf("trap cycle op=%0h", op), t, exp_idx);
        for (int c = 0; c < 8; c++) begin
            bus_if.op = 7'($urandom); bus_if.mem_ready = 1'($urandom); bus_if.zero = 1'($urandom);
            #1;
            held += int'(bus_if.illegal_instr);
            busy += int'(bus_if.mem_req | bus_if.mem_write | bus_if.reg_write | bus_if.pc_write | bus_if.ir_write);
            @(negedge clk);
        end
        chk("trap sticky", held, 8);
        chk("trap enables", busy, 0);
        bus_if.op = OP_R;
        rst = 1'b1;
        #1;
        chk("trap cleared by rst", outs(), 0);
        @(negedge clk);
        release_rst();
    endtask

    initial begin
        bus_if.op = OP_BEQ; bus_if.funct3 = 3'b000; bus_if.funct7_5 = 1'b0;
        bus_if.zero = 1'b1; bus_if.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset outputs", outs(), 0);
        release_rst();
        run_instr(0, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(1, 3'b010, 1'b0, 1'b0, 0, 3);
        run_instr(4, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr(4, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(5, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(2, 3'b000, 1'b1, 1'b0, 2, 0);
        run_instr(3, 3'b000, 1'b1, 1'b0, 1, 0);
        run_instr(0, 3'b010, 1'b0, 1'b0, 2, 3);
        for (int n = 0; n < 40; n++)
            run_instr($urandom_range(0, 5), legal_f3[$urandom_range(0, 3)], 1'($urandom),
                      1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        // reset in the middle of a stalled load
        bus_if.op = OP_LW; bus_if.funct3 = 3'b010;
        rw_seen = 0;
        step(1'b1); step(1'b0); step(1'b0); step(1'b0);
        bus_if.mem_ready = 1'b0;
        #1;
        chk("stalled in memread", {bus_if.mem_req, bus_if.adr_src, bus_if.mem_write}, 3'b110);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("outputs cleared mid-load", outs(), 0);
        @(negedge clk);
        release_rst();
        chk("no reg_write across reset", rw_seen + int'(bus_if.reg_write), 0);
        trap_test(7'h7F, 3'b000, 2);
        trap_test(OP_R, 3'b001, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
